// File: rtl/bleuart_pkg.sv
// ============================================================================
// Module      : bleuart_pkg
// Description : Shared constants and FSM state type for the BLE UART TX queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bleuart_pkg;

    localparam int c_BYTE_W          = 8;
    localparam int c_DEFAULT_DEPTH   = 16;
    localparam int c_DEFAULT_CLK_DIV = 434;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } tx_state_t;

endpackage : bleuart_pkg

`default_nettype wire

// File: rtl/bleuart_baud_tick.sv
// ============================================================================
// Module      : bleuart_baud_tick
// Description : Free-running divider; strobes tick once every CLK_DIV cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bleuart_baud_tick
    import bleuart_pkg::*;
#(
    parameter int CLK_DIV = c_DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int                 c_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               w_wrap;

    assign w_wrap = (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // Decoded from the counter register, so the period is exactly CLK_DIV.
    assign tick = w_wrap;

endmodule : bleuart_baud_tick

`default_nettype wire

// File: rtl/bleuart_tx_queue.sv
// ============================================================================
// Module      : bleuart_tx_queue
// Description : Byte FIFO, baud tick source and valid/rdy feeder for the
//               BLE UART byte transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bleuart_tx_queue
    import bleuart_pkg::*;
#(
    parameter int DEPTH   = c_DEFAULT_DEPTH,
    parameter int CLK_DIV = c_DEFAULT_CLK_DIV
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [c_BYTE_W-1:0]   wr_data,
    input  logic                  wr_en,
    input  logic                  flush,
    output logic                  full,
    output logic [$clog2(DEPTH):0] count,
    output logic                  overflow,
    output logic                  busy,
    output logic                  tick,
    output logic [c_BYTE_W-1:0]   byte_out,
    output logic                  byte_valid,
    input  logic                  byte_rdy
);

    localparam int                 c_PTR_W  = $clog2(DEPTH);
    localparam int                 c_CNT_W  = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH  = c_CNT_W'(DEPTH);

    logic [c_BYTE_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_overflow;
    logic [c_BYTE_W-1:0] r_byte_out;
    logic                r_byte_valid;
    tx_state_t           r_state;
    tx_state_t           w_next_state;
    logic                w_full;
    logic                w_push;
    logic                w_pop;

    bleuart_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Fullness is judged on the registered count, before any same-cycle pop.
    assign w_full = (r_count == c_DEPTH);
    assign w_push = wr_en && !w_full && !flush;

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (byte_rdy) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (wr_en && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    // byte_valid is a single-cycle strobe issued from IDLE; byte_out holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_out   <= '0;
            r_byte_valid <= 1'b0;
        end else begin
            r_byte_valid <= w_pop;
            if (w_pop) begin
                r_byte_out <= r_mem[r_rd_ptr];
            end
        end
    end

    assign full       = w_full;
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign busy       = (r_count != '0) || (r_state != ST_IDLE);
    assign byte_out   = r_byte_out;
    assign byte_valid = r_byte_valid;

endmodule : bleuart_tx_queue

`default_nettype wire

// File: tb/tb_bleuart_tx_queue.sv
// ============================================================================
// Module      : tb_bleuart_tx_queue
// Description : Scoreboard bench for bleuart_tx_queue with a UART TX model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bleuart_tx_queue;

    localparam int c_DEPTH   = 4;
    localparam int c_CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       flush;
    logic       full;
    logic [2:0] count;
    logic       overflow;
    logic       busy;
    logic       tick;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_rdy;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];
    logic [9:0] frame_q[$];

    // Transmitter model state
    logic       tx_stall;
    logic       spur_rdy;
    logic       m_busy;
    logic       m_rdy;
    logic       txd;
    logic [7:0] m_shift;
    logic [3:0] m_bit;
    logic [8:0] m_cap;
    logic       m_done;
    logic [9:0] m_frame;
    int         n_frames = 0;

    // Monitor observation state
    logic       prev_valid = 1'b0;
    int         max_count  = 0;
    logic       saw_full   = 1'b0;
    logic [7:0] mon_exp;
    logic [9:0] mon_frame;

    always #5 clk = ~clk;

    assign byte_rdy = m_rdy | spur_rdy;

    bleuart_tx_queue #(
        .DEPTH   (c_DEPTH),
        .CLK_DIV (c_CLK_DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .flush      (flush),
        .full       (full),
        .count      (count),
        .overflow   (overflow),
        .busy       (busy),
        .tick       (tick),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_rdy   (byte_rdy)
    );

    // Byte transmitter: start, 8 data LSB first, stop; rdy ends the stop bit.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_rdy   <= 1'b0;
            m_done  <= 1'b0;
            txd     <= 1'b1;
            m_bit   <= 4'd0;
            m_shift <= 8'h00;
            m_cap   <= 9'h000;
            m_frame <= 10'h000;
        end else begin
            m_rdy  <= 1'b0;
            m_done <= 1'b0;
            if (!m_busy) begin
                if (byte_valid) begin
                    m_busy  <= 1'b1;
                    m_shift <= byte_out;
                    m_bit   <= 4'd0;
                    txd     <= 1'b0;
                end
            end else if (tick) begin
                if (m_bit < 4'd9) begin
                    m_cap[m_bit] <= txd;
                    txd          <= (m_bit < 4'd8) ? m_shift[m_bit[2:0]] : 1'b1;
                    m_bit        <= m_bit + 4'd1;
                end else if (!tx_stall) begin
                    m_frame <= {txd, m_cap};
                    m_done  <= 1'b1;
                    m_rdy   <= 1'b1;
                    m_busy  <= 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_tx(input logic [7:0] b);
        exp_q.push_back(b);
        frame_q.push_back({1'b1, b, 1'b0});
    endtask

    task automatic wait_idle(input int limit);
        int k;
        for (k = 0; k < limit; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (k == limit) check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    // Monitor: pops expectations whenever the DUT or the TX model presents data.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (int'(count) > max_count) max_count = int'(count);
                if (full) saw_full = 1'b1;
                if (byte_valid) begin
                    n_checks++;
                    if (prev_valid) begin
                        n_errors++;
                        $display("FAIL valid_width: got 2+ cycles expected 1");
                    end else if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL unexpected_valid: got byte %0h expected none", byte_out);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if (byte_out !== mon_exp) begin
                            n_errors++;
                            $display("FAIL byte_out: got %0h expected %0h", byte_out, mon_exp);
                        end
                    end
                end
                if (m_done) begin
                    n_frames++;
                    n_checks++;
                    if (frame_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL unexpected_frame: got %0h expected none", m_frame);
                    end else begin
                        mon_frame = frame_q.pop_front();
                        if (m_frame !== mon_frame) begin
                            n_errors++;
                            $display("FAIL serial_frame: got %0h expected %0h", m_frame, mon_frame);
                        end
                    end
                end
            end
            prev_valid = byte_valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks;
        int first_tick;
        int last_tick;
        logic stray;
        int frames0;

        rst_n    = 1'b0;
        wr_data  = 8'h00;
        wr_en    = 1'b0;
        flush    = 1'b0;
        tx_stall = 1'b0;
        spur_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_count",    32'(count),      32'd0);
        check("rst_valid",    32'(byte_valid), 32'd0);
        check("rst_busy",     32'(busy),       32'd0);
        check("rst_full",     32'(full),       32'd0);
        check("rst_overflow", 32'(overflow),   32'd0);
        check("rst_tick",     32'(tick),       32'd0);

        // Idle: tick every 4th cycle, nothing else moves
        @(negedge clk);
        rst_n      = 1'b1;
        ticks      = 0;
        first_tick = 0;
        last_tick  = 0;
        stray      = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (tick) begin
                if (ticks == 0) first_tick = i;
                last_tick = i;
                ticks++;
            end
            if (byte_valid || busy || count != 3'd0) stray = 1'b1;
        end
        check("tick_count",  32'(ticks),                 32'd3);
        check("tick_first",  32'(first_tick),            32'd3);
        check("tick_period", 32'(last_tick - first_tick), 32'd8);
        check("idle_quiet",  32'(stray),                 32'd0);

        // Single byte 0xA5: valid exactly one edge after the write
        frames0 = n_frames;
        @(posedge clk); #1;
        wr_data = 8'hA5; wr_en = 1'b1;
        expect_tx(8'hA5);
        @(posedge clk); #1;
        wr_en = 1'b0;
        @(negedge clk);
        check("a5_count_after_write", 32'(count),      32'd1);
        check("a5_valid_before",      32'(byte_valid), 32'd0);
        @(negedge clk);
        check("a5_valid_at_e1", 32'(byte_valid), 32'd1);
        check("a5_count_at_e1", 32'(count),      32'd0);
        wait_idle(200);
        check("a5_frames", 32'(n_frames - frames0), 32'd1);

        // Burst of four: occupancy peaks at 3 because the first pop overlaps
        frames0   = n_frames;
        max_count = 0;
        saw_full  = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            wr_en = 1'b1; wr_data = 8'(i);
            expect_tx(8'(i));
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
        wait_idle(1000);
        check("burst_max_count", 32'(max_count), 32'd3);
        check("burst_no_full",   32'(saw_full),  32'd0);
        check("burst_frames",    32'(n_frames - frames0), 32'd4);

        // Stalled transmitter: bytes 1..5 accepted, 6th dropped
        tx_stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            wr_en = 1'b1; wr_data = 8'(8'h10 + i);
            if (i < 5) expect_tx(8'(8'h10 + i));
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
        @(negedge clk);
        check("ovf_count",    32'(count),    32'd4);
        check("ovf_full",     32'(full),     32'd1);
        check("ovf_overflow", 32'(overflow), 32'd1);
        tx_stall = 1'b0;
        wait_idle(2000);
        check("ovf_drained_q", 32'(exp_q.size()), 32'd0);

        // Flush while WAIT holds a byte and 3 are queued
        frames0  = n_frames;
        tx_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            wr_en = 1'b1; wr_data = 8'(8'h20 + i);
            if (i == 0) expect_tx(8'h20);
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
        @(negedge clk);
        check("flush_pre_count", 32'(count), 32'd3);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_count",    32'(count),    32'd0);
        check("flush_busy",     32'(busy),     32'd1);
        check("flush_overflow", 32'(overflow), 32'd1);
        tx_stall = 1'b0;
        wait_idle(500);
        repeat (20) @(negedge clk);
        check("flush_frames", 32'(n_frames - frames0), 32'd1);

        // Reset mid-frame, then a stale rdy must not trigger anything
        @(posedge clk); #1;
        wr_en = 1'b1; wr_data = 8'h5A;
        expect_tx(8'h5A);
        @(posedge clk); #1;
        wr_en = 1'b0;
        repeat (12) @(posedge clk);
        #3;
        rst_n = 1'b0;
        frame_q.delete();
        #1;
        check("mid_rst_valid",    32'(byte_valid), 32'd0);
        check("mid_rst_busy",     32'(busy),       32'd0);
        check("mid_rst_count",    32'(count),      32'd0);
        check("mid_rst_byte_out", 32'(byte_out),   32'd0);
        check("mid_rst_overflow", 32'(overflow),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        spur_rdy = 1'b1;
        @(posedge clk); #1;
        spur_rdy = 1'b0;
        repeat (20) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("final_exp_q",   32'(exp_q.size()),   32'd0);
        check("final_frame_q", 32'(frame_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_bleuart_tx_queue

`default_nettype wire
